// File: rtl/ajuste_horario.sv
`default_nettype none
// ============================================================================
//  Module   : ajuste_horario
//  Purpose  : Time-set controller for an HH:MM:SS BCD clock. Freezes the
//             counters, edits a shadow copy field by field, issues a one-cycle
//             parallel load on exit and blinks the field being edited.
//  Revision : 1.0  initial release
// ============================================================================
module ajuste_horario #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int TIMEOUT_S = 30
) (
  input  logic       ajuste_clock,
  input  logic       ajuste_reset,
  input  logic       ajuste_tick,
  input  logic       ajuste_btn_modo,
  input  logic       ajuste_btn_inc,
  input  logic [1:0] ajuste_h_msd_in,
  input  logic [3:0] ajuste_h_lsd_in,
  input  logic [2:0] ajuste_m_msd_in,
  input  logic [3:0] ajuste_m_lsd_in,
  input  logic [2:0] ajuste_s_msd_in,
  input  logic [3:0] ajuste_s_lsd_in,
  output logic       ajuste_run,
  output logic       ajuste_load,
  output logic [1:0] ajuste_h_msd_out,
  output logic [3:0] ajuste_h_lsd_out,
  output logic [2:0] ajuste_m_msd_out,
  output logic [3:0] ajuste_m_lsd_out,
  output logic [2:0] ajuste_s_msd_out,
  output logic [3:0] ajuste_s_lsd_out,
  output logic [5:0] ajuste_blank,
  output logic [1:0] ajuste_estado
);

  localparam logic [1:0] c_ST_RUN   = 2'd0;
  localparam logic [1:0] c_ST_SET_H = 2'd1;
  localparam logic [1:0] c_ST_SET_M = 2'd2;
  localparam logic [1:0] c_ST_SET_S = 2'd3;

  localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int c_TW = $clog2(TIMEOUT_S + 1);

  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);
  localparam logic [c_TW-1:0] c_TO_LAST    = c_TW'(TIMEOUT_S - 1);

  logic [1:0]      r_estado, w_estado_nxt;
  logic            r_run, w_run_nxt;
  logic            r_load, w_load_nxt;
  logic [1:0]      r_h_msd, w_h_msd_nxt;
  logic [3:0]      r_h_lsd, w_h_lsd_nxt;
  logic [2:0]      r_m_msd, w_m_msd_nxt;
  logic [3:0]      r_m_lsd, w_m_lsd_nxt;
  logic [2:0]      r_s_msd, w_s_msd_nxt;
  logic [3:0]      r_s_lsd, w_s_lsd_nxt;
  logic [c_TW-1:0] r_to, w_to_nxt;
  logic [c_BW-1:0] r_bcnt, w_bcnt_nxt;
  logic            r_phase, w_phase_nxt;
  logic [5:0]      r_blank, w_blank_nxt;

  // A mode pulse always wins, so an increment only counts when mode is idle
  logic w_btn, w_edit, w_timeout;
  assign w_btn     = ajuste_btn_modo | ajuste_btn_inc;
  assign w_edit    = (r_estado != c_ST_RUN) && ajuste_btn_inc && !ajuste_btn_modo;
  assign w_timeout = (r_estado != c_ST_RUN) && !w_btn && ajuste_tick && (r_to == c_TO_LAST);

  // State register
  always_ff @(posedge ajuste_clock or posedge ajuste_reset) begin
    if (ajuste_reset) r_estado <= c_ST_RUN;
    else              r_estado <= w_estado_nxt;
  end

  // Next-state: mode cycles the edit fields, timeout aborts straight to RUN
  always_comb begin
    w_estado_nxt = r_estado;
    case (r_estado)
      c_ST_RUN:   if (ajuste_btn_modo) w_estado_nxt = c_ST_SET_H;
      c_ST_SET_H: if (ajuste_btn_modo) w_estado_nxt = c_ST_SET_M;
                  else if (w_timeout)  w_estado_nxt = c_ST_RUN;
      c_ST_SET_M: if (ajuste_btn_modo) w_estado_nxt = c_ST_SET_S;
                  else if (w_timeout)  w_estado_nxt = c_ST_RUN;
      c_ST_SET_S: if (ajuste_btn_modo) w_estado_nxt = c_ST_RUN;
                  else if (w_timeout)  w_estado_nxt = c_ST_RUN;
      default:    w_estado_nxt = c_ST_RUN;
    endcase
  end

  // Output/datapath next values: shadow edits, timeout and blink counters, blank mask
  always_comb begin
    w_run_nxt   = (w_estado_nxt == c_ST_RUN);
    w_load_nxt  = (r_estado == c_ST_SET_S) && ajuste_btn_modo;
    w_h_msd_nxt = r_h_msd;
    w_h_lsd_nxt = r_h_lsd;
    w_m_msd_nxt = r_m_msd;
    w_m_lsd_nxt = r_m_lsd;
    w_s_msd_nxt = r_s_msd;
    w_s_lsd_nxt = r_s_lsd;

    if (r_estado == c_ST_RUN && ajuste_btn_modo) begin
      // Capture the pre-edge time; any advance on this same edge is ignored
      w_h_msd_nxt = ajuste_h_msd_in;
      w_h_lsd_nxt = ajuste_h_lsd_in;
      w_m_msd_nxt = ajuste_m_msd_in;
      w_m_lsd_nxt = ajuste_m_lsd_in;
      w_s_msd_nxt = ajuste_s_msd_in;
      w_s_lsd_nxt = ajuste_s_lsd_in;
    end else if (w_edit) begin
      case (r_estado)
        c_ST_SET_H: begin
          // Anything at or beyond 23 folds to 00 so the result stays in 00-23
          if ((r_h_msd == 2'd2 && r_h_lsd >= 4'd3) || r_h_msd == 2'd3) begin
            w_h_msd_nxt = 2'd0;
            w_h_lsd_nxt = 4'd0;
          end else if (r_h_lsd >= 4'd9) begin
            w_h_msd_nxt = r_h_msd + 2'd1;
            w_h_lsd_nxt = 4'd0;
          end else begin
            w_h_lsd_nxt = r_h_lsd + 4'd1;
          end
        end
        c_ST_SET_M: begin
          if (r_m_lsd >= 4'd9) begin
            w_m_lsd_nxt = 4'd0;
            w_m_msd_nxt = (r_m_msd >= 3'd5) ? 3'd0 : r_m_msd + 3'd1;
          end else begin
            w_m_lsd_nxt = r_m_lsd + 4'd1;
          end
        end
        default: begin
          w_s_msd_nxt = 3'd0;
          w_s_lsd_nxt = 4'd0;
        end
      endcase
    end

    // Inactivity counter: counts ticks while editing, any button restarts it
    if (r_estado == c_ST_RUN || w_estado_nxt != r_estado || w_btn) w_to_nxt = '0;
    else if (ajuste_tick)                                          w_to_nxt = r_to + c_TW'(1);
    else                                                           w_to_nxt = r_to;

    // Blink restarts in the visible phase on every state change and every increment
    if (r_estado == c_ST_RUN || w_estado_nxt != r_estado || w_edit) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (r_bcnt == c_BLINK_LAST) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = ~r_phase;
    end else begin
      w_bcnt_nxt  = r_bcnt + c_BW'(1);
      w_phase_nxt = r_phase;
    end

    case (w_estado_nxt)
      c_ST_SET_H: w_blank_nxt = 6'b110000 & {6{w_phase_nxt}};
      c_ST_SET_M: w_blank_nxt = 6'b001100 & {6{w_phase_nxt}};
      c_ST_SET_S: w_blank_nxt = 6'b000011 & {6{w_phase_nxt}};
      default:    w_blank_nxt = 6'b000000;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge ajuste_clock or posedge ajuste_reset) begin
    if (ajuste_reset) begin
      r_run   <= 1'b1;
      r_load  <= 1'b0;
      r_h_msd <= '0;
      r_h_lsd <= '0;
      r_m_msd <= '0;
      r_m_lsd <= '0;
      r_s_msd <= '0;
      r_s_lsd <= '0;
      r_to    <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_blank <= '0;
    end else begin
      r_run   <= w_run_nxt;
      r_load  <= w_load_nxt;
      r_h_msd <= w_h_msd_nxt;
      r_h_lsd <= w_h_lsd_nxt;
      r_m_msd <= w_m_msd_nxt;
      r_m_lsd <= w_m_lsd_nxt;
      r_s_msd <= w_s_msd_nxt;
      r_s_lsd <= w_s_lsd_nxt;
      r_to    <= w_to_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_phase <= w_phase_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  assign ajuste_estado    = r_estado;
  assign ajuste_run       = r_run;
  assign ajuste_load      = r_load;
  assign ajuste_h_msd_out = r_h_msd;
  assign ajuste_h_lsd_out = r_h_lsd;
  assign ajuste_m_msd_out = r_m_msd;
  assign ajuste_m_lsd_out = r_m_lsd;
  assign ajuste_s_msd_out = r_s_msd;
  assign ajuste_s_lsd_out = r_s_lsd;
  assign ajuste_blank     = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_ajuste_horario.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ajuste_horario
//  Purpose  : Scoreboard bench for ajuste_horario. A time-of-day model of the
//             external counters feeds the inputs; a behavioural model of the
//             controller predicts every cycle's outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ajuste_horario;

  localparam int BLINK_DIV = 4;
  localparam int TIMEOUT_S = 5;

  typedef logic [29:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, modo = 1'b0, inc = 1'b0;
  logic [1:0] h_msd_in;
  logic [3:0] h_lsd_in;
  logic [2:0] m_msd_in;
  logic [3:0] m_lsd_in;
  logic [2:0] s_msd_in;
  logic [3:0] s_lsd_in;
  logic       run_o, load_o;
  logic [1:0] h_msd_o;
  logic [3:0] h_lsd_o;
  logic [2:0] m_msd_o;
  logic [3:0] m_lsd_o;
  logic [2:0] s_msd_o;
  logic [3:0] s_lsd_o;
  logic [5:0] blank_o;
  logic [1:0] estado_o;

  always #5 clk = ~clk;

  ajuste_horario #(.BLINK_DIV(BLINK_DIV), .TIMEOUT_S(TIMEOUT_S)) dut (
    .ajuste_clock(clk), .ajuste_reset(rst), .ajuste_tick(tick),
    .ajuste_btn_modo(modo), .ajuste_btn_inc(inc),
    .ajuste_h_msd_in(h_msd_in), .ajuste_h_lsd_in(h_lsd_in),
    .ajuste_m_msd_in(m_msd_in), .ajuste_m_lsd_in(m_lsd_in),
    .ajuste_s_msd_in(s_msd_in), .ajuste_s_lsd_in(s_lsd_in),
    .ajuste_run(run_o), .ajuste_load(load_o),
    .ajuste_h_msd_out(h_msd_o), .ajuste_h_lsd_out(h_lsd_o),
    .ajuste_m_msd_out(m_msd_o), .ajuste_m_lsd_out(m_lsd_o),
    .ajuste_s_msd_out(s_msd_o), .ajuste_s_lsd_out(s_lsd_o),
    .ajuste_blank(blank_o), .ajuste_estado(estado_o)
  );

  // External clock counters, held as seconds of the day
  int t_now = 0;
  int t_next = 0;
  assign h_msd_in = 2'((t_now / 3600) / 10);
  assign h_lsd_in = 4'((t_now / 3600) % 10);
  assign m_msd_in = 3'(((t_now / 60) % 60) / 10);
  assign m_lsd_in = 4'(((t_now / 60) % 60) % 10);
  assign s_msd_in = 3'((t_now % 60) / 10);
  assign s_lsd_in = 4'((t_now % 60) % 10);

  // Controller reference model
  int m_state = 0;          // 0 RUN, 1 hours, 2 minutes, 3 seconds
  int m_h = 0, m_m = 0, m_s = 0;
  int m_to = 0;             // ticks since last button while editing
  int m_b = 0;              // cycles since blink restart
  bit m_load = 1'b0, m_run = 1'b1;

  int n_checks = 0, n_fail = 0, cyc = 0;
  vec_t q[$];

  function automatic vec_t pack_exp();
    logic [5:0] bl;
    bit ph;
    ph = ((m_b / BLINK_DIV) % 2) == 1;
    case (m_state)
      1:       bl = ph ? 6'b110000 : 6'b000000;
      2:       bl = ph ? 6'b001100 : 6'b000000;
      3:       bl = ph ? 6'b000011 : 6'b000000;
      default: bl = 6'b000000;
    endcase
    return {2'(m_state), m_run, m_load,
            2'(m_h / 10), 4'(m_h % 10), 3'(m_m / 10), 4'(m_m % 10),
            3'(m_s / 10), 4'(m_s % 10), bl};
  endfunction

  function automatic vec_t pack_dut();
    return {estado_o, run_o, load_o, h_msd_o, h_lsd_o, m_msd_o, m_lsd_o,
            s_msd_o, s_lsd_o, blank_o};
  endfunction

  task automatic check(string nm, vec_t got, vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (estado/run/load/hhmmss/blank)", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_to = 0; m_b = 0;
    m_load = 1'b0; m_run = 1'b1;
  endtask

  // One clock edge of the controller plus the counters it gates
  task automatic model_step(bit md, bit ic, bit tk);
    int pre_t, pre_sh;
    bit pre_load, pre_run;
    pre_t = t_now; pre_load = m_load; pre_run = m_run;
    pre_sh = m_h * 3600 + m_m * 60 + m_s;
    m_load = 1'b0;
    if (m_state == 0) begin
      if (md) begin
        m_state = 1; m_h = pre_t / 3600; m_m = (pre_t / 60) % 60; m_s = pre_t % 60;
        m_to = 0; m_b = 0;
      end
    end else if (md) begin
      m_load = (m_state == 3);
      m_state = (m_state == 3) ? 0 : m_state + 1;
      m_to = 0; m_b = 0;
    end else if (ic) begin
      if (m_state == 1)      m_h = (m_h + 1) % 24;
      else if (m_state == 2) m_m = (m_m + 1) % 60;
      else                   m_s = 0;
      m_to = 0; m_b = 0;
    end else begin
      if (tk) m_to++;
      if (m_to == TIMEOUT_S) begin
        m_state = 0; m_to = 0; m_b = 0;
      end else begin
        m_b++;
      end
    end
    m_run = (m_state == 0);
    q.push_back(pack_exp());
    if (pre_load)           t_next = pre_sh;
    else if (tk && pre_run) t_next = (pre_t + 1) % 86400;
    else                    t_next = pre_t;
  endtask

  task automatic step(bit md, bit ic, bit tk);
    @(negedge clk);
    modo = md; inc = ic; tick = tk;
    model_step(md, ic, tk);
    @(posedge clk);
    #2;
    t_now = t_next;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the registered outputs after every edge against the queue
  always @(posedge clk) begin
    vec_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("cycle %0d outputs", cyc), pack_dut(), e);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset state", pack_dut(), pack_exp());
    rst = 1'b0;

    // Ticks pass through while running
    for (int i = 0; i < 3; i++) begin step(0, 0, 1); step(0, 0, 0); end

    // 12:34:56 -> edit all fields to 00:00:00 and load
    t_now = 12 * 3600 + 34 * 60 + 56;
    step(1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    step(1, 0, 0);
    for (int i = 0; i < 26; i++) step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    idle(3);

    // Hours from 08 through the 23->00 wrap; tick on the capture edge
    t_now = 8 * 3600 + 59;
    step(1, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    idle(2);

    // Timeout: restart by an inc at tick TIMEOUT_S-1, then expire
    step(1, 0, 0);
    for (int i = 0; i < TIMEOUT_S - 1; i++) begin step(0, 0, 1); idle(2); end
    step(0, 1, 0);
    for (int i = 0; i < TIMEOUT_S; i++) begin step(0, 0, 1); idle(2); end
    step(0, 0, 1); idle(2);

    // Blink in SET_M, inc restarts phase, mode+inc keeps minutes
    step(1, 0, 0); step(1, 0, 0);
    idle(13);
    step(0, 1, 0);
    idle(6);
    step(1, 1, 0);
    idle(10);
    step(1, 0, 0);
    idle(2);

    // Asynchronous reset in the middle of an edit
    step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(1, 0, 0); idle(2);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check("reset mid-edit", pack_dut(), pack_exp());
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Random traffic: busy buttons, then sparse buttons so timeouts occur
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 30) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 1) == 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
